// File: rtl/thv_pkg.sv
// Shared constants and state encoding for the log2-to-float output stage.
package thv_pkg;

    localparam int LOG_W     = 33;
    localparam int FRAC_W    = 25;
    localparam int FP_BIAS   = 127;
    localparam int FP_MANT_W = 23;

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_DONE
    } thv_l2f_state_t;

endpackage

// File: rtl/thv_rne_round.sv
// Combinational round-to-nearest-even on a 23-bit mantissa with exponent carry.
module thv_rne_round
    import thv_pkg::*;
(
    input  logic [FP_MANT_W-1:0] mant,
    input  logic                 guard,
    input  logic                 sticky,
    input  logic [7:0]           exponent,
    output logic [FP_MANT_W-1:0] mant_rnd,
    output logic [7:0]           exponent_rnd,
    output logic                 inexact
);

    logic                 round_up;
    logic [FP_MANT_W:0]   mant_inc;

    // A carry out of the mantissa leaves it all-zero and bumps the exponent.
    always_comb begin
        round_up     = guard & (sticky | mant[0]);
        mant_inc     = {1'b0, mant} + {{FP_MANT_W{1'b0}}, round_up};
        mant_rnd     = mant_inc[FP_MANT_W-1:0];
        exponent_rnd = exponent + {7'd0, mant_inc[FP_MANT_W]};
        inexact      = guard | sticky;
    end

endmodule

// File: rtl/thv_log_to_fp.sv
// Converts the CORDIC core's sign-magnitude fixed-point log2 result to IEEE-754
// single precision using a one-bit-per-cycle normaliser and RNE rounding.
module thv_log_to_fp
    import thv_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [LOG_W-1:0] in_log,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      out_fp,
    output logic             out_inexact,
    output logic             out_valid,
    input  logic             out_ready
);

    // Exponent when the leading one already sits at bit 31 (k = 0).
    localparam logic [7:0] EXP_TOP = 8'(FP_BIAS + 31 - FRAC_W);

    thv_l2f_state_t       state;
    thv_l2f_state_t       next_state;
    logic [31:0]          mag;
    logic [4:0]           k;
    logic                 sign;
    logic                 zero;
    logic [7:0]           exponent;
    logic [FP_MANT_W-1:0] mant_rnd;
    logic [7:0]           exponent_rnd;
    logic                 inexact;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign exponent  = EXP_TOP - {3'd0, k};

    thv_rne_round u_round (
        .mant         (mag[30:8]),
        .guard        (mag[7]),
        .sticky       (|mag[6:0]),
        .exponent     (exponent),
        .mant_rnd     (mant_rnd),
        .exponent_rnd (exponent_rnd),
        .inexact      (inexact)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (in_valid) next_state = (in_log[31:0] == 32'd0) ? S_ROUND : S_NORM;
            S_NORM:  if (mag[31]) next_state = S_ROUND;
            S_ROUND: next_state = S_DONE;
            S_DONE:  if (out_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Results are written only in ROUND, so they stay frozen through DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mag         <= 32'd0;
            k           <= 5'd0;
            sign        <= 1'b0;
            zero        <= 1'b0;
            out_fp      <= 32'd0;
            out_inexact <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sign <= in_log[32];
                        mag  <= in_log[31:0];
                        k    <= 5'd0;
                        zero <= (in_log[31:0] == 32'd0);
                    end
                end
                S_NORM: begin
                    if (!mag[31]) begin
                        mag <= {mag[30:0], 1'b0};
                        k   <= k + 5'd1;
                    end
                end
                S_ROUND: begin
                    if (zero) begin
                        out_fp      <= 32'd0;
                        out_inexact <= 1'b0;
                    end else begin
                        out_fp      <= {sign, exponent_rnd, mant_rnd};
                        out_inexact <= inexact;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
